// File: rtl/mips_pkg.sv
// Shared ALU control codes and execute-stage FSM encoding.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, low WIDTH bits of the product.
// Latency: WIDTH cycles after start; done is a combinational strobe on the last iteration.
// Backpressure: none internally; flush aborts, start is only honoured when the caller is idle.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             active;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  // The final iteration's sum is the product, so it is offered before it is stored.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign product  = acc_next;
  assign done     = active && (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (flush) begin
      active <= 1'b0;
      count  <= '0;
    end else if (start) begin
      active <= 1'b1;
      count  <= CW'(WIDTH - 1);
      mcand  <= multiplicand;
      mplier <= multiplier;
      acc    <= '0;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - 1'b1;
      if (count == '0) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/OR/SLT, iterative MUL.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles to valid_out for MUL.
// Backpressure: busy (from state register only) stalls upstream during MUL; flush aborts.
module alu_multicycle
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             flush,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             valid_out,
  output logic             busy
);

  alu_state_t       state;
  alu_state_t       state_next;
  logic             alu_fire;
  logic             mul_start;
  logic             mul_capture;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_res;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .reset        (reset),
    .start        (mul_start),
    .flush        (flush),
    .multiplicand (srca),
    .multiplier   (srcb),
    .done         (mul_done),
    .product      (mul_product)
  );

  always_comb begin
    alu_res = '0;
    case (alucontrol)
      ALU_ADD: alu_res = srca + srcb;
      ALU_SUB: alu_res = srca - srcb;
      ALU_AND: alu_res = srca & srcb;
      ALU_OR:  alu_res = srca | srcb;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    alu_fire    = 1'b0;
    mul_start   = 1'b0;
    mul_capture = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in && !flush) begin
          if (alucontrol == ALU_MUL) begin
            mul_start  = 1'b1;
            state_next = MUL;
          end else begin
            alu_fire = 1'b1;
          end
        end
      end
      MUL: begin
        if (flush) begin
          state_next = IDLE;
        end else if (mul_done) begin
          mul_capture = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == MUL);

  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      zero      <= 1'b1;
      valid_out <= 1'b0;
    end else begin
      valid_out <= alu_fire || mul_capture;
      if (alu_fire) begin
        result <= alu_res;
        zero   <= (alu_res == '0);
      end else if (mul_capture) begin
        result <= mul_product;
        zero   <= (mul_product == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: vector table, multi-cycle corner cases, random ops.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        flush;
  logic [2:0]  alucontrol;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [31:0] result;
  logic        zero;
  logic        valid_out;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .flush      (flush),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .result     (result),
    .zero       (zero),
    .valid_out  (valid_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    logic        exp_z;
  } vec_t;

  // Reference model: plain arithmetic on the operation meaning.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned p;
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101: begin
        p = longint'(a) * longint'(b);
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    valid_in   = 1'b0;
    flush      = 1'b0;
    alucontrol = 3'b000;
    srca       = '0;
    srcb       = '0;
  endtask

  // Called at a negedge; offers one op, checks the result strobe one cycle later.
  task automatic do_single(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z);
    valid_in = 1'b1; alucontrol = op; srca = a; srcb = b;
    @(negedge clk);
    drive_idle();
    check({name, "_vo"}, 32'(valid_out), 32'd1);
    check({name, "_res"}, result, exp_r);
    check({name, "_zero"}, 32'(zero), 32'(exp_z));
    check({name, "_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({name, "_vo_off"}, 32'(valid_out), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge of the valid_out cycle with inputs idle.
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input bit toggle);
    int  busy_cnt;
    bit  saw_vo;
    bit  ended;
    busy_cnt = 0; saw_vo = 0; ended = 0;
    valid_in = 1'b1; alucontrol = 3'b101; srca = a; srcb = b;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ended = 1;
        break;
      end
      busy_cnt++;
      if (valid_out) saw_vo = 1;
      if (toggle) begin
        valid_in   = 1'($urandom_range(0, 1));
        alucontrol = 3'($urandom_range(0, 7));
        srca       = $urandom;
        srcb       = $urandom;
      end else begin
        drive_idle();
      end
    end
    drive_idle();
    if (!ended) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: busy still high after 40 cycles", name);
    end
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd32);
    check({name, "_vo_while_busy"}, 32'(saw_vo), 32'd0);
    check({name, "_vo"}, 32'(valid_out), 32'd1);
    check({name, "_res"}, result, ref_alu(3'b101, a, b));
    check({name, "_zero"}, 32'(zero), 32'(ref_alu(3'b101, a, b) == 32'd0));
  endtask

  vec_t vecs[$];
  logic [31:0] prior;
  logic [2:0]  ops[8] = '{3'b010, 3'b110, 3'b101, 3'b000, 3'b001, 3'b111, 3'b011, 3'b100};

  initial begin
    drive_idle();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    check("reset_res", result, 32'd0);
    check("reset_zero", 32'(zero), 32'd1);
    check("reset_vo", 32'(valid_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    vecs.push_back('{"add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0});
    vecs.push_back('{"sub_zero", 3'b110, 32'd5, 32'd5, 32'h0, 1'b1});
    vecs.push_back('{"slt_neg", 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0});
    vecs.push_back('{"slt_swap", 3'b111, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1});
    vecs.push_back('{"and", 3'b000, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0});
    vecs.push_back('{"or", 3'b001, 32'hA500_0000, 32'h0000_005A, 32'hA500_005A, 1'b0});
    vecs.push_back('{"sub_wrap", 3'b110, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{"undef011", 3'b011, 32'h1234, 32'h5678, 32'h0, 1'b1});
    vecs.push_back('{"undef100", 3'b100, 32'hFFFF, 32'h1, 32'h0, 1'b1});
    foreach (vecs[i])
      do_single(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].exp_z);

    // MUL with valid_in toggling during busy.
    run_mul("mul_shift", 32'h0001_2345, 32'h0000_0100, 1'b1);
    check("mul_shift_exact", result, 32'h0123_4500);
    @(negedge clk);

    // All-ones squared, then AND accepted in the valid_out cycle.
    run_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mul_ones_exact", result, 32'h0000_0001);
    valid_in = 1'b1; alucontrol = 3'b000; srca = 32'hF0F0; srcb = 32'h0FF0;
    @(negedge clk);
    drive_idle();
    check("b2b_and_vo", 32'(valid_out), 32'd1);
    check("b2b_and_res", result, 32'h0000_00F0);

    // Back-to-back MULs.
    run_mul("mul_b2b_a", 32'd7, 32'd9, 1'b0);
    run_mul("mul_b2b_b", 32'hDEAD_BEEF, 32'h0000_0003, 1'b0);
    @(negedge clk);

    // Flush in cycle N+10 of a MUL.
    prior = result;
    valid_in = 1'b1; alucontrol = 3'b101; srca = 32'd3; srcb = 32'd5;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      drive_idle();
    end
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_vo", 32'(valid_out), 32'd0);
    check("flush_res", result, prior);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid_out || busy) begin
        n_checks++; n_fail++;
        $display("FAIL flush_late: valid_out=%0b busy=%0b after abort", valid_out, busy);
        break;
      end
    end

    // Flush with valid_in in IDLE drops the op.
    valid_in = 1'b1; flush = 1'b1; alucontrol = 3'b010; srca = 32'd1; srcb = 32'd1;
    @(negedge clk);
    drive_idle();
    check("flush_idle_vo", 32'(valid_out), 32'd0);
    check("flush_idle_res", result, prior);
    valid_in = 1'b1; flush = 1'b1; alucontrol = 3'b101; srca = 32'd1; srcb = 32'd1;
    @(negedge clk);
    drive_idle();
    check("flush_idle_mul_busy", 32'(busy), 32'd0);

    // Reset mid-MUL.
    do_single("pre_reset", 3'b001, 32'h55, 32'h0, 32'h55, 1'b0);
    valid_in = 1'b1; alucontrol = 3'b101; srca = 32'd11; srcb = 32'd13;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_idle();
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_res", result, 32'd0);
    check("rst_mid_zero", 32'(zero), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_vo", 32'(valid_out), 32'd0);
    @(negedge clk);

    // Randomised ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (op == 3'b101) run_mul("rnd_mul", a, b, 1'b1);
      else do_single("rnd", op, a, b, ref_alu(op, a, b), ref_alu(op, a, b) == 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Execute-stage ALU that consumes the 3-bit `alucontrol` code from the ALU decoder and the two operands from the ID/EX register. ADD, SUB, AND, OR and SLT complete in one cycle. MUL runs as an iterative shift-add over WIDTH cycles, and the unit raises `busy` so the hazard unit stalls the front of the pipeline until the product is ready. Results are registered and handed to the EX/MEM register with a one-cycle `valid_out` strobe.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- `valid_in`  in  1  operation present on `alucontrol`/`srca`/`srcb` this cycle.
- `flush`  in  1  kill the in-flight or offered operation (branch mispredict / exception).
- `alucontrol`  in  3  010 add, 110 sub, 101 mul, 000 and, 001 or, 111 slt.
- `srca`  in  WIDTH  operand A.
- `srcb`  in  WIDTH  operand B.
- `result`  out  WIDTH  registered result; holds its last value until the next completion.
- `zero`  out  1  registered; high when `result` equals 0.
- `valid_out`  out  1  one-cycle strobe: `result`/`zero` were updated this cycle.
- `busy`  out  1  multiply in progress; upstream must hold and stall.

## Operation
- States: IDLE, MUL.
- **IDLE, `valid_in`=1, `flush`=0, non-MUL code:**
  - Compute and register `result` and `zero`.
  - Pulse `valid_out` next cycle; stay in IDLE.
- **IDLE, `valid_in`=1, `flush`=0, code 101:**
  - Load the multiplicand register with `srca` and the multiplier register with `srcb`.
  - Clear the accumulator and load the counter with WIDTH-1.
  - Go to MUL.
- **MUL, each cycle:**
  - If multiplier[0] is 1, add the multiplicand to the accumulator (WIDTH-bit, wraps).
  - Shift the multiplicand left 1 and the multiplier right 1; decrement the counter.
  - On the iteration where the counter is 0: write the final accumulator to `result`, set `zero`, pulse `valid_out` next cycle, go to IDLE.
- **Arithmetic rules:**
  - ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
  - SLT compares signed two's complement; result is 1 or 0, zero-extended.
  - MUL returns the low WIDTH bits of the product; this is identical for signed and unsigned operands.
- Undefined codes (011, 100): `result`=0, `zero`=1, `valid_out` pulses normally.
- `valid_in` is ignored while in MUL; upstream holds because `busy`=1.
- **`flush`:**
  - In MUL: abort and return to IDLE; no `valid_out`; `result` is unchanged.
  - In IDLE: blocks acceptance of `valid_in` in the same cycle.
- `reset` has priority over `flush`, which has priority over `valid_in`.
- Reset values: state IDLE, `result`=0, `zero`=1, `valid_out`=0, `busy`=0, counter 0. Reset mid-multiply discards it.

## Timing
- **Single-cycle ops:** accepted at the edge ending cycle N; `valid_out`=1 in cycle N+1.
- **MUL:**
  - Accepted at the edge ending cycle N.
  - `busy`=1 for cycles N+1 through N+WIDTH (32 cycles at the default).
  - `valid_out`=1 in cycle N+WIDTH+1, with `busy`=0 in that cycle.
- A new op may be accepted in the same cycle `valid_out` is high, so back-to-back MULs are legal.
- `busy` is decoded from the state register only (glitch-free); it never depends combinationally on `valid_in`.
- Latency is fixed; there is no early termination on zero operands.

## Structure
- A shared package `mips_pkg` holds:
  - the ALU control constants ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR, ALU_SLT, used by the decoder and this block;
  - the state encoding.
- One sub-module, `seq_multiplier`: the shift-add datapath with start/flush inputs, counter, `done` strobe and WIDTH-bit product.
- The top level holds the combinational single-cycle ALU, the FSM and the output registers.

## Test plan
- ADD 0x7FFFFFFF + 1 -> `result`=0x80000000, `zero`=0, `valid_out` one cycle later; SUB 5-5 -> `result`=0, `zero`=1.
- SLT srca=0xFFFFFFFF (-1), srcb=1 -> `result`=1; swapped operands -> `result`=0.
- MUL 0x00012345 × 0x00000100 -> `result`=0x01234500; `busy` high exactly 32 cycles; `valid_out` at cycle N+33; `valid_in` toggling while busy is ignored.
- MUL 0xFFFFFFFF × 0xFFFFFFFF -> `result`=0x00000001; immediately followed by AND 0xF0F0 & 0x0FF0 accepted in the `valid_out` cycle -> 0x00F0 one cycle later.
- Flush at cycle N+10 of a MUL -> no `valid_out`, `busy` drops next cycle, `result` keeps its prior value; flush and `valid_in` together in IDLE -> op dropped.
- Reset asserted mid-MUL -> next cycle `result`=0, `zero`=1, `busy`=0, `valid_out`=0; undefined code 011 -> `result`=0, `valid_out` pulses.
